// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions.
//   ADDR_W     - register address width
//   MEM_CNT_W  - width of the multi-cycle memory wait counter
//   hz_state_t - hazard FSM states
package pipe_pkg;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned MEM_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the
// instruction in ID.
// Ports:
//   src_add, dst_add   - ID operand register addresses
//   use_src, use_dst   - ID instruction reads the matching operand
//   ex_wr_add          - EX write address
//   ex_wb, ex_mem_read - EX instruction writes back / is a load
//   hazard             - load-use hazard present
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [ADDR_W-1:0] src_add,
    input  logic [ADDR_W-1:0] dst_add,
    input  logic              use_src,
    input  logic              use_dst,
    input  logic [ADDR_W-1:0] ex_wr_add,
    input  logic              ex_wb,
    input  logic              ex_mem_read,
    output logic              hazard
);

    logic src_hit;
    logic dst_hit;

    always_comb begin
        src_hit = use_src && (src_add == ex_wr_add);
        dst_hit = use_dst && (dst_add == ex_wr_add);
        hazard  = ex_mem_read && ex_wb && (src_hit || dst_hit);
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: resolves hazards the forwarding unit cannot: load-use stall,
// multi-cycle data-memory freeze and taken-branch flush.
// Ports:
//   clk, rst (async, active-low)
//   id_src_add, id_dst_add, id_use_src, id_use_dst - ID operand info
//   ex_wr_add, ex_wb, ex_mem_read                  - EX instruction info
//   mem_access   - MEM instruction accesses data memory (held whole residency)
//   branch_taken - branch resolved taken in EX
//   pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en, mem_wb_bubble
//                - pipeline control (combinational)
//   stall_count  - saturating count of cycles with pc_en=0
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_CYCLES = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] id_src_add,
    input  logic [ADDR_W-1:0] id_dst_add,
    input  logic              id_use_src,
    input  logic              id_use_dst,
    input  logic [ADDR_W-1:0] ex_wr_add,
    input  logic              ex_wb,
    input  logic              ex_mem_read,
    input  logic              mem_access,
    input  logic              branch_taken,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pipe_en,
    output logic              mem_wb_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    // WAIT covers all frozen cycles except the first (in RUN), hence the -3.
    localparam logic [MEM_CNT_W-1:0] CNT_INIT =
        (MEM_CYCLES >= 3) ? MEM_CNT_W'(MEM_CYCLES - 3) : '0;
    localparam logic MULTI_CYCLE = (MEM_CYCLES > 1);
    localparam logic TWO_CYCLE   = (MEM_CYCLES == 2);

    hz_state_t            state;
    logic [MEM_CNT_W-1:0] cnt;
    logic                 load_use;
    logic                 mem_start;
    logic                 freeze;

    load_use_detect u_load_use_detect (
        .src_add     (id_src_add),
        .dst_add     (id_dst_add),
        .use_src     (id_use_src),
        .use_dst     (id_use_dst),
        .ex_wr_add   (ex_wr_add),
        .ex_wb       (ex_wb),
        .ex_mem_read (ex_mem_read),
        .hazard      (load_use)
    );

    always_comb begin
        mem_start = (state == RUN) && mem_access && MULTI_CYCLE;
        freeze    = mem_start || (state == WAIT);
    end

    // Priority: reset, freeze, branch, load-use, normal.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        pipe_en       = 1'b1;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            pipe_en       = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            pipe_en       = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
        end else if (load_use) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_start) begin
                        if (TWO_CYCLE) begin
                            state <= RELEASE;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt - MEM_CNT_W'(1);
                    end
                end
                RELEASE: begin
                    // Same instruction still in MEM; mem_access is ignored.
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (!pc_en && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed test of hazard_unit across several parameterisations
// sharing one stimulus bus.
module tb_hazard_unit;

    // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en, mem_wb_bubble}
    localparam logic [5:0] O_NORMAL = 6'b110010;
    localparam logic [5:0] O_FREEZE = 6'b000001;
    localparam logic [5:0] O_BRANCH = 6'b111110;
    localparam logic [5:0] O_LDUSE  = 6'b000110;
    localparam logic [5:0] O_RESET  = 6'b001101;

    logic       clk;
    logic       rst;
    logic [2:0] id_src_add;
    logic [2:0] id_dst_add;
    logic       id_use_src;
    logic       id_use_dst;
    logic [2:0] ex_wr_add;
    logic       ex_wb;
    logic       ex_mem_read;
    logic       mem_access;
    logic       branch_taken;

    logic [5:0]  out1, out3, out4, out2c;
    logic [15:0] sc1, sc3, sc4;
    logic [1:0]  sc2c;

    int unsigned checks;
    int unsigned errors;

    hazard_unit #(.MEM_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .id_src_add(id_src_add), .id_dst_add(id_dst_add),
        .id_use_src(id_use_src), .id_use_dst(id_use_dst), .ex_wr_add(ex_wr_add),
        .ex_wb(ex_wb), .ex_mem_read(ex_mem_read), .mem_access(mem_access),
        .branch_taken(branch_taken), .pc_en(out1[5]), .if_id_en(out1[4]),
        .if_id_flush(out1[3]), .id_ex_bubble(out1[2]), .pipe_en(out1[1]),
        .mem_wb_bubble(out1[0]), .stall_count(sc1)
    );

    hazard_unit #(.MEM_CYCLES(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .id_src_add(id_src_add), .id_dst_add(id_dst_add),
        .id_use_src(id_use_src), .id_use_dst(id_use_dst), .ex_wr_add(ex_wr_add),
        .ex_wb(ex_wb), .ex_mem_read(ex_mem_read), .mem_access(mem_access),
        .branch_taken(branch_taken), .pc_en(out3[5]), .if_id_en(out3[4]),
        .if_id_flush(out3[3]), .id_ex_bubble(out3[2]), .pipe_en(out3[1]),
        .mem_wb_bubble(out3[0]), .stall_count(sc3)
    );

    hazard_unit #(.MEM_CYCLES(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .id_src_add(id_src_add), .id_dst_add(id_dst_add),
        .id_use_src(id_use_src), .id_use_dst(id_use_dst), .ex_wr_add(ex_wr_add),
        .ex_wb(ex_wb), .ex_mem_read(ex_mem_read), .mem_access(mem_access),
        .branch_taken(branch_taken), .pc_en(out4[5]), .if_id_en(out4[4]),
        .if_id_flush(out4[3]), .id_ex_bubble(out4[2]), .pipe_en(out4[1]),
        .mem_wb_bubble(out4[0]), .stall_count(sc4)
    );

    hazard_unit #(.MEM_CYCLES(2), .CNT_W(2)) u_dut2c (
        .clk(clk), .rst(rst), .id_src_add(id_src_add), .id_dst_add(id_dst_add),
        .id_use_src(id_use_src), .id_use_dst(id_use_dst), .ex_wr_add(ex_wr_add),
        .ex_wb(ex_wb), .ex_mem_read(ex_mem_read), .mem_access(mem_access),
        .branch_taken(branch_taken), .pc_en(out2c[5]), .if_id_en(out2c[4]),
        .if_id_flush(out2c[3]), .id_ex_bubble(out2c[2]), .pipe_en(out2c[1]),
        .mem_wb_bubble(out2c[0]), .stall_count(sc2c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_src_add   = 3'd0;
        id_dst_add   = 3'd0;
        id_use_src   = 1'b0;
        id_use_dst   = 1'b0;
        ex_wr_add    = 3'd0;
        ex_wb        = 1'b0;
        ex_mem_read  = 1'b0;
        mem_access   = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1;
        ex_wb       = 1'b1;
        ex_wr_add   = 3'd3;
        id_src_add  = 3'd3;
        id_use_src  = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        step();
        rst = 1'b0;
        clear_inputs();
        #1;
        check_eq({tag, "_rst_out"}, 32'(out3), 32'(O_RESET));
        check_eq({tag, "_rst_cnt"}, 32'(sc3), 32'd0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        clear_inputs();

        // Load-use on source operand
        do_reset("lu");
        step(); set_load_use(); sample();
        check_eq("lu_stall", 32'(out3), 32'(O_LDUSE));
        step(); clear_inputs(); sample();
        check_eq("lu_after", 32'(out3), 32'(O_NORMAL));
        check_eq("lu_cnt", 32'(sc3), 32'd1);

        // Load-use on second operand
        do_reset("lud");
        step(); set_load_use(); id_use_src = 1'b0; id_use_dst = 1'b1; id_dst_add = 3'd3;
        id_src_add = 3'd5; sample();
        check_eq("lud_stall", 32'(out3), 32'(O_LDUSE));

        // Negatives
        do_reset("neg");
        step(); set_load_use(); ex_wb = 1'b0; sample();
        check_eq("neg_nowb", 32'(out3), 32'(O_NORMAL));
        step(); set_load_use(); id_use_src = 1'b0; id_use_dst = 1'b0; sample();
        check_eq("neg_nouse", 32'(out3), 32'(O_NORMAL));
        step(); set_load_use(); ex_wr_add = 3'd4; sample();
        check_eq("neg_addr", 32'(out3), 32'(O_NORMAL));
        step(); clear_inputs(); sample();
        check_eq("neg_cnt", 32'(sc3), 32'd0);

        // MEM_CYCLES=3 freeze, then back-to-back access
        do_reset("mem");
        step(); mem_access = 1'b1; sample();
        check_eq("mem_c1", 32'(out3), 32'(O_FREEZE));
        check_eq("mem1_nofreeze", 32'(out1), 32'(O_NORMAL));
        step(); sample();
        check_eq("mem_c2", 32'(out3), 32'(O_FREEZE));
        step(); sample();
        check_eq("mem_c3", 32'(out3), 32'(O_NORMAL));
        check_eq("mem_cnt", 32'(sc3), 32'd2);
        step(); sample();
        check_eq("b2b_c1", 32'(out3), 32'(O_FREEZE));
        step(); sample();
        check_eq("b2b_c2", 32'(out3), 32'(O_FREEZE));
        step(); sample();
        check_eq("b2b_c3", 32'(out3), 32'(O_NORMAL));
        step(); mem_access = 1'b0; sample();
        check_eq("b2b_idle", 32'(out3), 32'(O_NORMAL));
        check_eq("b2b_cnt", 32'(sc3), 32'd4);
        check_eq("mem1_cnt", 32'(sc1), 32'd0);

        // Branch overrides load-use
        do_reset("br");
        step(); set_load_use(); branch_taken = 1'b1; sample();
        check_eq("br_out", 32'(out3), 32'(O_BRANCH));
        step(); clear_inputs(); sample();
        check_eq("br_cnt", 32'(sc3), 32'd0);

        // MEM_CYCLES=4 freeze with branch held into RELEASE
        do_reset("m4");
        step(); mem_access = 1'b1; sample();
        check_eq("m4_c1", 32'(out4), 32'(O_FREEZE));
        step(); branch_taken = 1'b1; sample();
        check_eq("m4_c2", 32'(out4), 32'(O_FREEZE));
        step(); sample();
        check_eq("m4_c3", 32'(out4), 32'(O_FREEZE));
        check_eq("m3_rel_br", 32'(out3), 32'(O_BRANCH));
        step(); sample();
        check_eq("m4_rel_br", 32'(out4), 32'(O_BRANCH));
        check_eq("m4_cnt", 32'(sc4), 32'd3);
        step(); clear_inputs(); sample();
        check_eq("m4_after", 32'(out4), 32'(O_NORMAL));

        // Reset during WAIT
        do_reset("rw");
        step(); mem_access = 1'b1; sample();
        check_eq("rw_c1", 32'(out4), 32'(O_FREEZE));
        step(); sample();
        check_eq("rw_c2", 32'(out4), 32'(O_FREEZE));
        step(); rst = 1'b0; #1;
        check_eq("rw_rst_out", 32'(out4), 32'(O_RESET));
        check_eq("rw_rst_cnt", 32'(sc4), 32'd0);
        step(); mem_access = 1'b0; rst = 1'b1; sample();
        check_eq("rw_run", 32'(out4), 32'(O_NORMAL));

        // Counter saturation with CNT_W=2
        do_reset("sat");
        step(); set_load_use();
        repeat (5) step();
        clear_inputs(); sample();
        check_eq("sat_cnt2", 32'(sc2c), 32'd3);
        check_eq("sat_cnt16", 32'(sc3), 32'd5);
        check_eq("sat_out", 32'(out2c), 32'(O_NORMAL));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
